// File: rtl/tri_bus_tx_ctrl.sv
// Serialises a handshaked parallel word onto a shared single-wire bus through a
// tri-state driver, wrapping each frame in lead/trail guard intervals.
module tri_bus_tx_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BIT_CYC   = 4,
  parameter int unsigned GUARD_CYC = 2,
  parameter logic        IDLE_LVL  = 1'b1,
  parameter logic        EN_POL    = 1'b1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  output logic              oReady,
  output logic              oA,
  output logic              oEna,
  output logic              oBusy,
  output logic              oDone
);

  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned BW = (DATA_W    > 1) ? $clog2(DATA_W)    : 1;
  localparam int unsigned CW = (BIT_CYC   > 1) ? $clog2(BIT_CYC)   : 1;

  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic [BW-1:0]     bit_q,   bit_d;
  logic [CW-1:0]     cyc_q,   cyc_d;
  logic [DATA_W-1:0] sr_q,    sr_d;
  logic              ready_q, ready_d;
  logic              a_q,     a_d;
  logic              ena_q,   ena_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  // Outputs are computed for the cycle following the edge, so every pin is a flop.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    sr_d    = sr_q;
    ready_d = ready_q;
    a_d     = a_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        ena_d   = ~EN_POL;
        a_d     = IDLE_LVL;
        if (iValid && ready_q) begin
          state_d = LEAD;
          guard_d = '0;
          sr_d    = iData;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ena_d   = EN_POL;
        end
      end
      LEAD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = SHIFT;
          bit_d   = '0;
          cyc_d   = '0;
          a_d     = sr_q[0];
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            // Release the bus before the trail guard; oA parks at idle level.
            state_d = TRAIL;
            guard_d = '0;
            ena_d   = ~EN_POL;
            a_d     = IDLE_LVL;
            done_d  = (GUARD_CYC == 1);
          end else begin
            bit_d = bit_q + 1'b1;
            sr_d  = sr_q >> 1;
            a_d   = sr_d[0];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      TRAIL: begin
        if (guard_q == GUARD_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          guard_d = guard_q + 1'b1;
          done_d  = (GW'(guard_q + 1'b1) == GUARD_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      guard_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      sr_q    <= '0;
      ready_q <= 1'b0;
      a_q     <= IDLE_LVL;
      ena_q   <= ~EN_POL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oReady = ready_q;
  assign oA     = a_q;
  assign oEna   = ena_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

endmodule

// File: tb/tb_tri_bus_tx_ctrl.sv
// Directed bench for tri_bus_tx_ctrl: default-parameter instance plus a
// DATA_W=4 / BIT_CYC=1 / GUARD_CYC=1 corner instance.
module tb_tri_bus_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, val_a;
  logic [7:0] dat_a;
  logic       rdy_a, a_a, ena_a, busy_a, done_a;

  logic       rst_b, val_b;
  logic [3:0] dat_b;
  logic       rdy_b, a_b, ena_b, busy_b, done_b;

  tri_bus_tx_ctrl u_dut (
    .iClk(clk), .iRst_n(rst_a), .iValid(val_a), .iData(dat_a),
    .oReady(rdy_a), .oA(a_a), .oEna(ena_a), .oBusy(busy_a), .oDone(done_a)
  );

  tri_bus_tx_ctrl #(.DATA_W(4), .BIT_CYC(1), .GUARD_CYC(1)) u_small (
    .iClk(clk), .iRst_n(rst_b), .iValid(val_b), .iData(dat_b),
    .oReady(rdy_b), .oA(a_b), .oEna(ena_b), .oBusy(busy_b), .oDone(done_b)
  );

  // exp packs {ready, a, ena, busy, done} as seen just after the edge
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int G = 2;
  localparam int B = 4;
  localparam int W = 8;

  task automatic chk(input string name, input int cyc, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got {rdy,a,ena,busy,done}=%b exp=%b", name, cyc, got, exp);
  endtask

  function automatic logic [4:0] outs_a();
    return {rdy_a, a_a, ena_a, busy_a, done_a};
  endfunction

  function automatic logic [4:0] outs_b();
    return {rdy_b, a_b, ena_b, busy_b, done_b};
  endfunction

  // Reference frame waveform: value present in cycle c after handshake edge E0
  function automatic logic [4:0] model_exp(input logic [7:0] d, input int c);
    if (c <= G)                 return 5'b01110;
    else if (c <= G + W*B)      return {1'b0, d[(c - G - 1) / B], 3'b110};
    else if (c <= 2*G + W*B)    return {4'b0101, 1'(c == 2*G + W*B)};
    else                        return 5'b11000;
  endfunction

  // Runs one frame on u_dut; inputs for E0 must already be driven.
  task automatic frame_a(input logic [7:0] d, input logic hold_v, input int pulse_at,
                         input int abort_at, input logic next_v, input logic [7:0] next_d,
                         input string name);
    for (int j = 0; j < 2*G + W*B + 1; j++) begin
      @(posedge clk); #1;
      if (abort_at > 0 && j == abort_at) begin
        chk({name, "_abort_edge"}, j, outs_a(), 5'b01000);
        return;
      end
      chk(name, j + 1, outs_a(), model_exp(d, j + 1));
      if (j == 2*G + W*B) begin
        val_a = next_v;
        dat_a = next_d;
      end else begin
        val_a = (j + 1 == pulse_at) ? 1'b1 : hold_v;
        dat_a = (j + 1 == pulse_at) ? 8'h3C : d;
        if (abort_at > 0 && j + 1 == abort_at) rst_a = 1'b0;
      end
    end
  endtask

  task automatic idle_a(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(name, i, outs_a(), 5'b11000);
    end
  endtask

  vec_t vb[9];
  vec_t va[5];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Corner instance: 0x6 sent LSB first gives 0,1,1,0 after a 1-cycle lead
    vb[0] = '{1'b0, 1'b0, 8'h0, 5'b01000};
    vb[1] = '{1'b1, 1'b0, 8'h0, 5'b11000};
    vb[2] = '{1'b1, 1'b1, 8'h6, 5'b01110};
    vb[3] = '{1'b1, 1'b0, 8'h6, 5'b00110};
    vb[4] = '{1'b1, 1'b0, 8'h6, 5'b01110};
    vb[5] = '{1'b1, 1'b0, 8'h6, 5'b01110};
    vb[6] = '{1'b1, 1'b0, 8'h6, 5'b00110};
    vb[7] = '{1'b1, 1'b0, 8'h6, 5'b01011};
    vb[8] = '{1'b1, 1'b0, 8'h6, 5'b11000};
    // Reset held with iValid high; first released edge only raises oReady
    va[0] = '{1'b0, 1'b1, 8'hA5, 5'b01000};
    va[1] = '{1'b0, 1'b1, 8'hA5, 5'b01000};
    va[2] = '{1'b0, 1'b1, 8'hA5, 5'b01000};
    va[3] = '{1'b1, 1'b1, 8'hA5, 5'b11000};
    va[4] = '{1'b1, 1'b0, 8'hA5, 5'b11000};

    rst_a = 1'b0; val_a = 1'b0; dat_a = 8'h00;
    rst_b = 1'b0; val_b = 1'b0; dat_b = 4'h0;

    for (int i = 0; i < 9; i++) begin
      rst_b = vb[i].rst_n; val_b = vb[i].valid; dat_b = vb[i].data[3:0];
      @(posedge clk); #1;
      chk("corner_small", i, outs_b(), vb[i].exp);
    end
    val_b = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rst_a = va[i].rst_n; val_a = va[i].valid; dat_a = va[i].data;
      @(posedge clk); #1;
      chk("reset_seq", i, outs_a(), va[i].exp);
    end

    val_a = 1'b1; dat_a = 8'hA5;
    frame_a(8'hA5, 1'b0, -1, -1, 1'b0, 8'h00, "frame_a5");
    idle_a(1, "idle_after_a5");

    val_a = 1'b1; dat_a = 8'h00;
    frame_a(8'h00, 1'b1, -1, -1, 1'b1, 8'hFF, "b2b_00");
    frame_a(8'hFF, 1'b0, -1, -1, 1'b0, 8'h00, "b2b_ff");
    idle_a(1, "idle_after_b2b");

    val_a = 1'b1; dat_a = 8'h81;
    frame_a(8'h81, 1'b0, 10, -1, 1'b0, 8'h00, "ignored_req_81");
    idle_a(8, "no_second_frame");

    val_a = 1'b1; dat_a = 8'hFF;
    frame_a(8'hFF, 1'b0, -1, 20, 1'b0, 8'h00, "abort_ff");
    rst_a = 1'b1; val_a = 1'b0;
    idle_a(6, "after_abort");

    val_a = 1'b1; dat_a = 8'h5A;
    frame_a(8'h5A, 1'b0, -1, -1, 1'b0, 8'h00, "post_abort_5a");
    idle_a(2, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
